// File: rtl/mux_pkg.sv
// Shared types for the TDM multiplexer: controller states and mode encodings.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1.sv
// Parametrised N-to-1 combinational channel selector over a packed bus.
module mux_nto1 #(
  parameter int N = 16,
  parameter int W = 1
) (
  input  logic [N*W-1:0]         in,
  input  logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           y
);

  localparam int SW = $clog2(N);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) y = in[k*W +: W];
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// TDM multiplexer: direct channel select or sequential scan of all channels,
// with a registered valid/ready output stage.
module tdm_mux
  import mux_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in,
  input  logic [$clog2(N)-1:0] sel,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 loop,
  input  logic                 out_ready,
  output logic [W-1:0]         y,
  output logic [$clog2(N)-1:0] out_ch,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] ch, ch_nxt, mux_sel;
  logic [W-1:0]  mux_y;
  logic          load_pend, load_pend_nxt;
  logic          load, valid_nxt, done_nxt;
  logic          xfer, can_load;

  assign xfer     = out_valid & out_ready;
  assign can_load = ~out_valid | out_ready;

  mux_nto1 #(.N(N), .W(W)) u_mux (
    .in  (in),
    .sel (mux_sel),
    .y   (mux_y)
  );

  // load_pend marks a freshly started scan whose channel 0 has not been
  // loaded yet; it lets an older pending output drain before channel 0 lands.
  always_comb begin
    state_nxt     = state;
    ch_nxt        = ch;
    load_pend_nxt = load_pend;
    mux_sel       = sel;
    load          = 1'b0;
    valid_nxt     = out_valid;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          if (can_load) begin
            load      = 1'b1;
            valid_nxt = 1'b1;
          end
        end else begin
          if (xfer) valid_nxt = 1'b0;
          if (start) begin
            state_nxt     = SCAN;
            ch_nxt        = '0;
            load_pend_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (load_pend) begin
          mux_sel = ch;
          if (can_load) begin
            load          = 1'b1;
            valid_nxt     = 1'b1;
            load_pend_nxt = 1'b0;
          end
        end else begin
          mux_sel = ch + 1'b1;
          if (xfer) begin
            if (ch == LAST && !loop) begin
              state_nxt = IDLE;
              ch_nxt    = '0;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              ch_nxt    = mux_sel;
              load      = 1'b1;
              valid_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      load_pend <= 1'b0;
      y         <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      load_pend <= load_pend_nxt;
      out_valid <= valid_nxt;
      done      <= done_nxt;
      if (load) begin
        y      <= mux_y;
        out_ch <= mux_sel;
      end
    end
  end

  assign busy = (state == SCAN);

endmodule
